sata_link_init_ctrl: RTL and testbench

- Per-port link bring-up sequencer for the SATA GTX/GTP PHY wrapper. One instance per port (port 0 and port 1).
- Waits for PLL lock, pulses the PHY reset, issues COMRESET via StartComm, then waits for linkup. On timeout it backs off and retries.
- Raises link_ready to the link layer and link_err to the AHCI port registers.
- Restarts automatically on link drop, on an unsolicited COMINIT from the device, or on a software COMRESET request.

---
 rtl/sata_link_pkg.sv | 27 ++
 rtl/sata_link_timer.sv | 28 ++
 rtl/sata_link_init_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sata_link_init_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_link_pkg.sv
// Shared constants for the SATA per-port link bring-up sequencer.
// State encoding is fixed because software reads it back through state_o.
// Default cycle counts are given for 75 MHz and 150 MHz phyclk.
package sata_link_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_PLL_WAIT  = 3'd1;
  localparam logic [ST_W-1:0] ST_PHY_RST   = 3'd2;
  localparam logic [ST_W-1:0] ST_COMRESET  = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_LINK = 3'd4;
  localparam logic [ST_W-1:0] ST_LINK_UP   = 3'd5;
  localparam logic [ST_W-1:0] ST_BACKOFF   = 3'd6;
  localparam logic [ST_W-1:0] ST_FAIL      = 3'd7;

  // 75 MHz phyclk: 10 ms link timeout, 100 us backoff.
  localparam int RST_CYCLES_75     = 16;
  localparam int LINK_TIMEOUT_75   = 750000;
  localparam int BACKOFF_CYCLES_75 = 7500;

  // 150 MHz phyclk: same wall-clock intervals.
  localparam int RST_CYCLES_150     = 32;
  localparam int LINK_TIMEOUT_150   = 1500000;
  localparam int BACKOFF_CYCLES_150 = 15000;

endpackage

// File: rtl/sata_link_timer.sv
// Loadable down-counter shared by the PHY reset, link wait and backoff phases.
// Load takes effect on the next edge; the count then decrements to 0 and holds.
// expired is a decode of the current count (value == 0).
module sata_link_timer #(
  parameter int C_CNT_W = 24
) (
  input  logic               phyclk,
  input  logic               phyreset,
  input  logic               load,
  input  logic [C_CNT_W-1:0] load_val,
  output logic [C_CNT_W-1:0] value,
  output logic               expired
);

  // Load wins over counting; the count parks at zero once expired.
  always_ff @(posedge phyclk or posedge phyreset) begin
    if (phyreset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - C_CNT_W'(1);
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/sata_link_init_ctrl.sv
// Per-port SATA link bring-up: PLL wait, PHY reset pulse, COMRESET, linkup wait, backoff/retry.
// Outputs are registered from the next-state decode, so they change together with state_o.
// Optional stats counters (linkup_cnt, drop_cnt) are built only when SATA_LINK_STATS_EN is defined.
module sata_link_init_ctrl
  import sata_link_pkg::*;
#(
  parameter int C_RST_CYCLES     = RST_CYCLES_75,
  parameter int C_LINK_TIMEOUT   = LINK_TIMEOUT_75,
  parameter int C_BACKOFF_CYCLES = BACKOFF_CYCLES_75,
  parameter int C_MAX_RETRY      = 3,
  parameter int C_CNT_W          = 24
) (
  input  logic        phyclk,
  input  logic        phyreset,
  input  logic        enable,
  input  logic        comreset_req,
  input  logic        plllock,
  input  logic        linkup,
  input  logic        comm_init,
  output logic        phyreset_o,
  output logic        start_comm,
  output logic        link_ready,
  output logic        link_err,
  output logic [3:0]  retry_cnt,
  output logic [2:0]  state_o,
  output logic [15:0] linkup_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [C_CNT_W-1:0] LD_RST     = C_CNT_W'(C_RST_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] LD_TIMEOUT = C_CNT_W'(C_LINK_TIMEOUT - 1);
  localparam logic [C_CNT_W-1:0] LD_BACKOFF = C_CNT_W'(C_BACKOFF_CYCLES - 1);
  localparam logic [3:0]         MAX_RETRY  = 4'(C_MAX_RETRY);

  logic [ST_W-1:0]    state;
  logic [ST_W-1:0]    nxt;
  logic               ld;
  logic [C_CNT_W-1:0] ld_val;
  logic [C_CNT_W-1:0] timer_val_unused;
  logic               timer_exp;
  logic [3:0]         nxt_retry;
  logic [3:0]         retry_inc;
  logic               nxt_err;
  logic               inc_up;
  logic               inc_drop;
  logic               ci_q;
  logic               ci_rise;
  logic               ci_restart;

  // One timer serves every timed phase; its raw count is left available for debug probing.
  sata_link_timer #(.C_CNT_W(C_CNT_W)) u_timer (
    .phyclk   (phyclk),
    .phyreset (phyreset),
    .load     (ld),
    .load_val (ld_val),
    .value    (timer_val_unused),
    .expired  (timer_exp)
  );

  assign ci_rise    = comm_init & ~ci_q;
  assign ci_restart = ci_rise & ((state == ST_LINK_UP) | (state == ST_BACKOFF) | (state == ST_FAIL));
  assign retry_inc  = (retry_cnt >= MAX_RETRY) ? MAX_RETRY : retry_cnt + 4'd1;

  // Next-state logic: restart events first (enable, PLL loss, COMRESET/COMINIT), then the normal sequence.
  always_comb begin
    nxt       = state;
    ld        = 1'b0;
    ld_val    = '0;
    nxt_retry = retry_cnt;
    nxt_err   = link_err;
    inc_up    = 1'b0;
    inc_drop  = 1'b0;
    if (!enable) begin
      nxt       = ST_IDLE;
      nxt_retry = 4'd0;
      nxt_err   = 1'b0;
    end else if (!plllock && (state != ST_IDLE) && (state != ST_PLL_WAIT)) begin
      nxt = ST_PLL_WAIT;
    end else if (comreset_req || ci_restart) begin
      nxt       = ST_PHY_RST;
      ld        = 1'b1;
      ld_val    = LD_RST;
      nxt_retry = 4'd0;
      nxt_err   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: nxt = ST_PLL_WAIT;
        ST_PLL_WAIT: begin
          if (plllock) begin
            nxt    = ST_PHY_RST;
            ld     = 1'b1;
            ld_val = LD_RST;
          end
        end
        ST_PHY_RST: begin
          if (timer_exp) nxt = ST_COMRESET;
        end
        ST_COMRESET: begin
          nxt    = ST_WAIT_LINK;
          ld     = 1'b1;
          ld_val = LD_TIMEOUT;
        end
        ST_WAIT_LINK: begin
          // linkup takes precedence over a timeout landing on the same cycle
          if (linkup) begin
            nxt       = ST_LINK_UP;
            nxt_retry = 4'd0;
            inc_up    = 1'b1;
          end else if (timer_exp) begin
            nxt_retry = retry_inc;
            if (retry_inc == MAX_RETRY) begin
              nxt     = ST_FAIL;
              nxt_err = 1'b1;
            end else begin
              nxt    = ST_BACKOFF;
              ld     = 1'b1;
              ld_val = LD_BACKOFF;
            end
          end
        end
        ST_LINK_UP: begin
          if (!linkup) begin
            nxt      = ST_BACKOFF;
            ld       = 1'b1;
            ld_val   = LD_BACKOFF;
            inc_drop = 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (timer_exp) begin
            nxt    = ST_PHY_RST;
            ld     = 1'b1;
            ld_val = LD_RST;
          end
        end
        ST_FAIL: nxt = ST_FAIL;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // State and all outputs registered together, decoded from the next state.
  always_ff @(posedge phyclk or posedge phyreset) begin
    if (phyreset) begin
      state      <= ST_IDLE;
      phyreset_o <= 1'b1;
      start_comm <= 1'b0;
      link_ready <= 1'b0;
      link_err   <= 1'b0;
      retry_cnt  <= 4'd0;
      ci_q       <= 1'b0;
    end else begin
      state      <= nxt;
      phyreset_o <= (nxt == ST_IDLE) | (nxt == ST_PLL_WAIT) | (nxt == ST_PHY_RST);
      start_comm <= (nxt == ST_COMRESET);
      link_ready <= (nxt == ST_LINK_UP);
      link_err   <= nxt_err;
      retry_cnt  <= nxt_retry;
      ci_q       <= comm_init;
    end
  end

  assign state_o = state;

`ifdef SATA_LINK_STATS_EN
  logic [15:0] up_q;
  logic [15:0] drop_q;

  // Saturating link-up / link-drop event counters, cleared only by phyreset.
  always_ff @(posedge phyclk or posedge phyreset) begin
    if (phyreset) begin
      up_q   <= 16'd0;
      drop_q <= 16'd0;
    end else begin
      if (inc_up && (up_q != 16'hFFFF)) up_q <= up_q + 16'd1;
      if (inc_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign linkup_cnt = up_q;
  assign drop_cnt   = drop_q;
`else
  logic stats_unused;
  assign stats_unused = inc_up ^ inc_drop;
  assign linkup_cnt   = 16'd0;
  assign drop_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_sata_link_init_ctrl.sv
// Bench for sata_link_init_ctrl: vector table, directed corner sequences, randomized run vs. reference model.
module tb_sata_link_init_ctrl;

  localparam int RST = 4;
  localparam int TO  = 20;
  localparam int BO  = 8;
  localparam int MR  = 3;
`ifdef SATA_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        phyclk;
  logic        phyreset;
  logic        enable;
  logic        comreset_req;
  logic        plllock;
  logic        linkup;
  logic        comm_init;
  logic        phyreset_o;
  logic        start_comm;
  logic        link_ready;
  logic        link_err;
  logic [3:0]  retry_cnt;
  logic [2:0]  state_o;
  logic [15:0] linkup_cnt;
  logic [15:0] drop_cnt;

  sata_link_init_ctrl #(
    .C_RST_CYCLES(RST), .C_LINK_TIMEOUT(TO), .C_BACKOFF_CYCLES(BO),
    .C_MAX_RETRY(MR), .C_CNT_W(24)
  ) dut (
    .phyclk(phyclk), .phyreset(phyreset), .enable(enable), .comreset_req(comreset_req),
    .plllock(plllock), .linkup(linkup), .comm_init(comm_init), .phyreset_o(phyreset_o),
    .start_comm(start_comm), .link_ready(link_ready), .link_err(link_err),
    .retry_cnt(retry_cnt), .state_o(state_o), .linkup_cnt(linkup_cnt), .drop_cnt(drop_cnt)
  );

  initial phyclk = 1'b0;
  always #5 phyclk = ~phyclk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pack(input logic [2:0] st, input logic prst, input logic sc,
                                       input logic rdy, input logic err, input logic [3:0] rc,
                                       input int ups, input int drops);
    logic [15:0] u;
    logic [15:0] d;
    u = STATS ? 16'(ups) : 16'd0;
    d = STATS ? 16'(drops) : 16'd0;
    return {5'd0, st, prst, sc, rdy, err, rc, u, d};
  endfunction

  function automatic logic [47:0] dut_vec();
    return {5'd0, state_o, phyreset_o, start_comm, link_ready, link_err, retry_cnt, linkup_cnt, drop_cnt};
  endfunction

  // Reference model: phase number plus cycles-spent-in-phase; phase lengths come straight from the parameters.
  int m_st, m_age, m_retry, m_ups, m_drops;
  bit m_err, m_ci;

  task automatic model_reset();
    m_st = 0; m_age = 0; m_retry = 0; m_ups = 0; m_drops = 0; m_err = 0; m_ci = 0;
  endtask

  task automatic model_step(input bit en, input bit pll, input bit lu, input bit cr, input bit ci);
    int nx;
    bit fresh;
    bit rise;
    rise = ci && !m_ci;
    m_ci = ci;
    nx = m_st;
    fresh = 0;
    if (!en) begin
      nx = 0; m_retry = 0; m_err = 0;
    end else if (!pll && m_st >= 2) begin
      nx = 1;
    end else if (cr || (rise && (m_st == 5 || m_st == 6 || m_st == 7))) begin
      nx = 2; fresh = 1; m_retry = 0; m_err = 0;
    end else begin
      case (m_st)
        0: nx = 1;
        1: if (pll) nx = 2;
        2: if (m_age >= RST - 1) nx = 3;
        3: nx = 4;
        4: begin
          if (lu) begin
            nx = 5; m_retry = 0;
            if (m_ups < 65535) m_ups++;
          end else if (m_age >= TO - 1) begin
            m_retry = (m_retry + 1 > MR) ? MR : m_retry + 1;
            if (m_retry == MR) begin nx = 7; m_err = 1; end
            else nx = 6;
          end
        end
        5: if (!lu) begin nx = 6; if (m_drops < 65535) m_drops++; end
        6: if (m_age >= BO - 1) nx = 2;
        default: nx = m_st;
      endcase
    end
    if (nx != m_st || fresh) m_age = 0;
    else m_age++;
    m_st = nx;
  endtask

  function automatic logic [47:0] model_vec();
    return pack(3'(m_st), m_st <= 2, m_st == 3, m_st == 5, m_err, 4'(m_retry), m_ups, m_drops);
  endfunction

  task automatic clk1();
    @(posedge phyclk);
    if (!phyreset) model_step(enable, plllock, linkup, comreset_req, comm_init);
    #1;
  endtask

  typedef struct {
    logic en, pll, lu, cr, ci;
    int n;
    logic [2:0] st;
    logic prst, sc, rdy, err;
    logic [3:0] rc;
    int ups, drops;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic pll, input logic lu, input logic cr,
                              input logic ci, input int n, input logic [2:0] st, input logic prst,
                              input logic sc, input logic rdy, input logic err, input logic [3:0] rc,
                              input int ups, input int drops);
    vec_t v;
    v.en = en; v.pll = pll; v.lu = lu; v.cr = cr; v.ci = ci; v.n = n;
    v.st = st; v.prst = prst; v.sc = sc; v.rdy = rdy; v.err = err; v.rc = rc;
    v.ups = ups; v.drops = drops;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[21];
    int npulse;
    int pt[4];
    bit prev_sc;
    bit dbl;
    int hi;
    int f0;

    enable = 0; plllock = 0; linkup = 0; comreset_req = 0; comm_init = 0; phyreset = 1;
    model_reset();

    // Bring-up, link, drop, relink, COMINIT restart.
    tbl[0]  = mk(1,1,0,0,0, 1, 3'd1,1,0,0,0,4'd0, 0,0);
    tbl[1]  = mk(1,1,0,0,0, 1, 3'd2,1,0,0,0,4'd0, 0,0);
    tbl[2]  = mk(1,1,0,0,0, 3, 3'd2,1,0,0,0,4'd0, 0,0);
    tbl[3]  = mk(1,1,0,0,0, 1, 3'd3,0,1,0,0,4'd0, 0,0);
    tbl[4]  = mk(1,1,0,0,0, 1, 3'd4,0,0,0,0,4'd0, 0,0);
    tbl[5]  = mk(1,1,0,0,0, 8, 3'd4,0,0,0,0,4'd0, 0,0);
    tbl[6]  = mk(1,1,1,0,0, 1, 3'd5,0,0,1,0,4'd0, 1,0);
    tbl[7]  = mk(1,1,1,0,0, 5, 3'd5,0,0,1,0,4'd0, 1,0);
    tbl[8]  = mk(1,1,0,0,0, 1, 3'd6,0,0,0,0,4'd0, 1,1);
    tbl[9]  = mk(1,1,0,0,0, 7, 3'd6,0,0,0,0,4'd0, 1,1);
    tbl[10] = mk(1,1,0,0,0, 1, 3'd2,1,0,0,0,4'd0, 1,1);
    tbl[11] = mk(1,1,0,0,0, 3, 3'd2,1,0,0,0,4'd0, 1,1);
    tbl[12] = mk(1,1,0,0,0, 1, 3'd3,0,1,0,0,4'd0, 1,1);
    tbl[13] = mk(1,1,1,0,0, 1, 3'd4,0,0,0,0,4'd0, 1,1);
    tbl[14] = mk(1,1,1,0,0, 1, 3'd5,0,0,1,0,4'd0, 2,1);
    tbl[15] = mk(1,1,1,0,1, 1, 3'd2,1,0,0,0,4'd0, 2,1);
    tbl[16] = mk(1,1,1,0,1, 1, 3'd2,1,0,0,0,4'd0, 2,1);
    tbl[17] = mk(1,1,1,0,0, 2, 3'd2,1,0,0,0,4'd0, 2,1);
    tbl[18] = mk(1,1,1,0,0, 1, 3'd3,0,1,0,0,4'd0, 2,1);
    tbl[19] = mk(1,1,1,0,0, 1, 3'd4,0,0,0,0,4'd0, 2,1);
    tbl[20] = mk(1,1,1,0,0, 1, 3'd5,0,0,1,0,4'd0, 3,1);

    repeat (3) @(posedge phyclk);
    #1;
    check("reset_values", dut_vec(), pack(3'd0,1,0,0,0,4'd0,0,0));
    phyreset = 0;
    clk1();
    check("idle_while_disabled", dut_vec(), pack(3'd0,1,0,0,0,4'd0,0,0));

    for (int i = 0; i < 21; i++) begin
      enable = tbl[i].en; plllock = tbl[i].pll; linkup = tbl[i].lu;
      comreset_req = tbl[i].cr; comm_init = tbl[i].ci;
      repeat (tbl[i].n) clk1();
      check($sformatf("table_row%0d", i), dut_vec(),
            pack(tbl[i].st, tbl[i].prst, tbl[i].sc, tbl[i].rdy, tbl[i].err, tbl[i].rc,
                 tbl[i].ups, tbl[i].drops));
    end
    comreset_req = 0; comm_init = 0;

    // Retries exhausted: three StartComm pulses 33 cycles apart, then FAIL.
    enable = 0;
    clk1();
    check("t2_idle", {state_o, link_err, retry_cnt}, {3'd0, 1'b0, 4'd0});
    enable = 1; plllock = 1; linkup = 0;
    npulse = 0; prev_sc = 0; dbl = 0;
    for (int i = 0; i < 4; i++) pt[i] = 0;
    for (int c = 0; c < 400 && state_o != 3'd7; c++) begin
      clk1();
      if (start_comm) begin
        if (npulse < 4) pt[npulse] = c;
        npulse++;
        if (prev_sc) dbl = 1;
      end
      prev_sc = start_comm;
    end
    check("t2_pulse_count", 48'(npulse), 48'd3);
    check("t2_gap1", 48'(pt[1] - pt[0]), 48'd33);
    check("t2_gap2", 48'(pt[2] - pt[1]), 48'd33);
    check("t2_single_cycle_sc", 48'(dbl), 48'd0);
    check("t2_fail", {state_o, link_err, retry_cnt}, {3'd7, 1'b1, 4'd3});
    repeat (5) clk1();
    check("t2_fail_hold", {state_o, link_err, link_ready}, {3'd7, 1'b1, 1'b0});

    // Software COMRESET out of FAIL.
    comreset_req = 1;
    clk1();
    comreset_req = 0;
    check("t3_clear", {state_o, link_err, retry_cnt}, {3'd2, 1'b0, 4'd0});
    hi = 0;
    while (phyreset_o && hi < 20) begin
      hi++;
      clk1();
    end
    check("t3_phyrst_width", 48'(hi), 48'd4);
    check("t3_start_comm", {state_o, start_comm}, {3'd3, 1'b1});

    // PLL loss in WAIT_LINK, then enable=0 beats comreset_req.
    clk1();
    check("t5_wait_link", 48'(state_o), 48'd4);
    plllock = 0;
    clk1();
    check("t5_pll_wait", {state_o, phyreset_o}, {3'd1, 1'b1});
    comreset_req = 1; enable = 0;
    clk1();
    comreset_req = 0;
    check("t5_idle_wins", {state_o, phyreset_o, retry_cnt}, {3'd0, 1'b1, 4'd0});

    // Async reset in the middle of a second WAIT_LINK attempt.
    enable = 1; plllock = 1; linkup = 0;
    for (int c = 0; c < 200 && !(retry_cnt == 4'd1 && state_o == 3'd4); c++) clk1();
    check("t6_reach", {retry_cnt, state_o}, {4'd1, 3'd4});
    repeat (3) clk1();
    #3;
    phyreset = 1;
    #1;
    check("t6_async_reset", dut_vec(), pack(3'd0,1,0,0,0,4'd0,0,0));
    model_reset();
    repeat (2) clk1();
    phyreset = 0;

    // Randomized run against the reference model.
    f0 = fails;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 2) == 0) enable = 1;
      if ($urandom_range(0, 249) == 0) plllock = 0;
      else if (!plllock && $urandom_range(0, 3) == 0) plllock = 1;
      if (((i / 600) % 2) == 1) linkup = 0;
      else if ($urandom_range(0, 14) == 0) linkup = ~linkup;
      comreset_req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 24) == 0) comm_init = ~comm_init;
      clk1();
      if (fails - f0 < 10) check($sformatf("random_cycle%0d", i), dut_vec(), model_vec());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
